// File: rtl/pack_pkg.sv
// Shared constants, capture FSM encoding and saturating-counter helper
// for the pack ring buffer.
package pack_pkg;

   localparam int DEF_DATA_W = 24;
   localparam int DEF_NCH    = 3;
   localparam int DEF_TS_W   = 32;
   localparam int DEF_DEPTH  = 4000;

   typedef enum logic {
      IDLE = 1'b0,
      CAP  = 1'b1
   } cap_state_t;

   // Increment that sticks at the all-ones value of a w-bit counter.
   function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
      logic [31:0] mx;
      if (w >= 32)
         mx = '1;
      else
         mx = (32'd1 << w) - 32'd1;
      sat_inc = (v >= mx) ? mx : v + 32'd1;
   endfunction

endpackage

// File: rtl/ram_sdp.sv
// Simple dual-port RAM: one write port, one registered read-first read port.
module ram_sdp #(
   parameter int W  = 8,
   parameter int AW = 4
) (
   input  logic          clk_sys,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [W-1:0]  wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [W-1:0]  rd_data
);

   logic [W-1:0] mem [2**AW];

   always_ff @(posedge clk_sys) begin
      if (wr_en)
         mem[wr_addr] <= wr_data;
   end

   // Same-address read and write returns the old word; the buffer relies on
   // this when popping and committing together at full.
   always_ff @(posedge clk_sys) begin
      if (rst)
         rd_data <= '0;
      else if (rd_en)
         rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/pack_ring_buf.sv
// Captures framed multi-channel samples with timestamps into a circular
// record store and hands them out FIFO-style to the packet assembler.
module pack_ring_buf
   import pack_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int NCH    = DEF_NCH,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int AW     = 12,
   parameter int TS_W   = DEF_TS_W,
   parameter int CNT_W  = 16
) (
   input  logic                  clk_sys,
   input  logic                  rst,
   input  logic [DATA_W-1:0]     dp_data,
   input  logic                  dp_vld,
   input  logic [TS_W-1:0]       dp_utc,
   input  logic [TS_W-1:0]       dp_ns,
   input  logic                  flush,
   input  logic                  rd_pop,
   output logic [NCH*DATA_W-1:0] q_data,
   output logic [TS_W-1:0]       q_utc,
   output logic [TS_W-1:0]       q_ns,
   output logic                  q_vld,
   output logic [AW-1:0]         buf_waddr,
   output logic [AW-1:0]         buf_raddr,
   output logic [AW:0]           buf_level,
   output logic                  empty,
   output logic                  full,
   output logic                  ovf,
   output logic [CNT_W-1:0]      ovf_cnt,
   output logic [CNT_W-1:0]      short_cnt,
   output logic [CNT_W-1:0]      long_cnt
);

   localparam int              LANES_W = NCH * DATA_W;
   localparam int              RW      = 2 * TS_W + LANES_W;
   localparam int              SCW     = $clog2(NCH + 2);
   localparam logic [SCW-1:0]  NCH_C   = SCW'(NCH);
   localparam logic [SCW-1:0]  LONG_C  = SCW'(NCH + 1);
   localparam logic [AW-1:0]   LAST_C  = AW'(DEPTH - 1);
   localparam logic [AW:0]     DEPTH_C = (AW + 1)'(DEPTH);

   cap_state_t                 state, state_nxt;
   logic                       dp_vld_d;
   logic [SCW-1:0]             sample_cnt;
   logic [NCH-1:0][DATA_W-1:0] lanes;
   logic [TS_W-1:0]            cap_utc, cap_ns;
   logic [AW-1:0]              waddr, raddr;
   logic [AW:0]                level;
   logic                       ovf_r, q_vld_r;
   logic [CNT_W-1:0]           ovf_cnt_r, short_cnt_r, long_cnt_r;
   logic                       rise;
   logic                       do_start, do_lane, do_commit, do_short, do_ovf, do_long, do_pop;
   logic [RW-1:0]              wr_word, rd_word;

   assign rise = dp_vld & ~dp_vld_d;

   // Frame tracking; the falling cycle of dp_vld decides commit or drop.
   always_comb begin
      state_nxt = state;
      do_start  = 1'b0;
      do_lane   = 1'b0;
      do_commit = 1'b0;
      do_short  = 1'b0;
      do_ovf    = 1'b0;
      do_long   = 1'b0;
      do_pop    = rd_pop && (level != '0) && !flush;
      case (state)
         IDLE: begin
            if (rise) begin
               do_start  = 1'b1;
               state_nxt = CAP;
            end
         end
         CAP: begin
            if (dp_vld) begin
               do_lane = 1'b1;
            end else begin
               state_nxt = IDLE;
               if (sample_cnt < NCH_C)
                  do_short = 1'b1;
               else if (level == DEPTH_C && !do_pop)
                  do_ovf = 1'b1;
               else begin
                  do_commit = 1'b1;
                  do_long   = (sample_cnt > NCH_C);
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (flush) begin
         state_nxt = IDLE;
         do_start  = 1'b0;
         do_lane   = 1'b0;
         do_commit = 1'b0;
         do_short  = 1'b0;
         do_ovf    = 1'b0;
         do_long   = 1'b0;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (rst) begin
         state      <= IDLE;
         dp_vld_d   <= 1'b0;
         sample_cnt <= '0;
         lanes      <= '0;
         cap_utc    <= '0;
         cap_ns     <= '0;
      end else begin
         state    <= state_nxt;
         dp_vld_d <= dp_vld;
         if (do_start) begin
            lanes[0]   <= dp_data;
            cap_utc    <= dp_utc;
            cap_ns     <= dp_ns;
            sample_cnt <= SCW'(1);
         end else if (do_lane) begin
            for (int i = 1; i < NCH; i++) begin
               if (sample_cnt == SCW'(i))
                  lanes[i] <= dp_data;
            end
            if (sample_cnt != LONG_C)
               sample_cnt <= sample_cnt + SCW'(1);
         end
      end
   end

   // Pointers and fill level; a simultaneous commit and pop leave level unchanged.
   always_ff @(posedge clk_sys) begin
      if (rst || flush) begin
         waddr <= '0;
         raddr <= '0;
         level <= '0;
      end else begin
         if (do_commit)
            waddr <= (waddr == LAST_C) ? '0 : waddr + AW'(1);
         if (do_pop)
            raddr <= (raddr == LAST_C) ? '0 : raddr + AW'(1);
         if (do_commit && !do_pop)
            level <= level + (AW + 1)'(1);
         else if (do_pop && !do_commit)
            level <= level - (AW + 1)'(1);
      end
   end

   always_ff @(posedge clk_sys) begin
      if (rst) begin
         ovf_r       <= 1'b0;
         ovf_cnt_r   <= '0;
         short_cnt_r <= '0;
         long_cnt_r  <= '0;
         q_vld_r     <= 1'b0;
      end else begin
         q_vld_r <= do_pop;
         if (do_ovf) begin
            ovf_r     <= 1'b1;
            ovf_cnt_r <= CNT_W'(sat_inc(32'(ovf_cnt_r), CNT_W));
         end
         if (do_short)
            short_cnt_r <= CNT_W'(sat_inc(32'(short_cnt_r), CNT_W));
         if (do_long)
            long_cnt_r <= CNT_W'(sat_inc(32'(long_cnt_r), CNT_W));
      end
   end

   assign wr_word = {cap_ns, cap_utc, lanes};

   ram_sdp #(
      .W  (RW),
      .AW (AW)
   ) u_ram (
      .clk_sys (clk_sys),
      .rst     (rst),
      .wr_en   (do_commit),
      .wr_addr (waddr),
      .wr_data (wr_word),
      .rd_en   (do_pop),
      .rd_addr (raddr),
      .rd_data (rd_word)
   );

   assign q_data    = rd_word[LANES_W-1:0];
   assign q_utc     = rd_word[LANES_W +: TS_W];
   assign q_ns      = rd_word[LANES_W+TS_W +: TS_W];
   assign q_vld     = q_vld_r;
   assign buf_waddr = waddr;
   assign buf_raddr = raddr;
   assign buf_level = level;
   assign empty     = (level == '0);
   assign full      = (level == DEPTH_C);
   assign ovf       = ovf_r;
   assign ovf_cnt   = ovf_cnt_r;
   assign short_cnt = short_cnt_r;
   assign long_cnt  = long_cnt_r;

endmodule

// File: tb/tb_pack_ring_buf.sv
// Directed self-checking bench for pack_ring_buf with a 4-record store.
module tb_pack_ring_buf;

   localparam int DATA_W = 24;
   localparam int NCH    = 3;
   localparam int DEPTH  = 4;
   localparam int AW     = 2;
   localparam int TS_W   = 32;
   localparam int CNT_W  = 16;

   logic                  clk_sys = 1'b0;
   logic                  rst;
   logic [DATA_W-1:0]     dp_data;
   logic                  dp_vld;
   logic [TS_W-1:0]       dp_utc, dp_ns;
   logic                  flush, rd_pop;
   logic [NCH*DATA_W-1:0] q_data;
   logic [TS_W-1:0]       q_utc, q_ns;
   logic                  q_vld;
   logic [AW-1:0]         buf_waddr, buf_raddr;
   logic [AW:0]           buf_level;
   logic                  empty, full, ovf;
   logic [CNT_W-1:0]      ovf_cnt, short_cnt, long_cnt;

   int checks   = 0;
   int failures = 0;

   pack_ring_buf #(
      .DATA_W (DATA_W),
      .NCH    (NCH),
      .DEPTH  (DEPTH),
      .AW     (AW),
      .TS_W   (TS_W),
      .CNT_W  (CNT_W)
   ) dut (
      .clk_sys   (clk_sys),
      .rst       (rst),
      .dp_data   (dp_data),
      .dp_vld    (dp_vld),
      .dp_utc    (dp_utc),
      .dp_ns     (dp_ns),
      .flush     (flush),
      .rd_pop    (rd_pop),
      .q_data    (q_data),
      .q_utc     (q_utc),
      .q_ns      (q_ns),
      .q_vld     (q_vld),
      .buf_waddr (buf_waddr),
      .buf_raddr (buf_raddr),
      .buf_level (buf_level),
      .empty     (empty),
      .full      (full),
      .ovf       (ovf),
      .ovf_cnt   (ovf_cnt),
      .short_cnt (short_cnt),
      .long_cnt  (long_cnt)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [23:0] sampleOf(input logic [7:0] id, input int i);
      return {id, 16'(i)};
   endfunction

   function automatic logic [71:0] frameWord(input logic [7:0] id);
      return {id, 16'd2, id, 16'd1, id, 16'd0};
   endfunction

   // Drives one dp_vld window of nsamp samples, then the commit (falling) cycle.
   task automatic applyStimulus(input int nsamp, input logic [7:0] id, input logic popAtCommit);
      for (int i = 0; i < nsamp; i++) begin
         dp_vld  = 1'b1;
         dp_data = sampleOf(id, i);
         dp_utc  = 32'(id);
         dp_ns   = 32'(id) * 32'd10;
         tick();
      end
      dp_vld  = 1'b0;
      dp_data = '0;
      rd_pop  = popAtCommit;
      tick();
      rd_pop  = 1'b0;
   endtask

   task automatic popOne();
      rd_pop = 1'b1;
      tick();
      rd_pop = 1'b0;
   endtask

   initial begin
      logic [AW-1:0] wexp;
      rst = 1'b1; dp_data = '0; dp_vld = 1'b0; dp_utc = '0; dp_ns = '0;
      flush = 1'b0; rd_pop = 1'b0;
      tick(); tick();
      rst = 1'b0;
      tick();
      checkOutput("rst_level", 128'(buf_level), 128'd0);
      checkOutput("rst_empty", 128'(empty), 128'd1);
      checkOutput("rst_full",  128'(full),  128'd0);
      checkOutput("rst_qvld",  128'(q_vld), 128'd0);
      checkOutput("rst_qdata", 128'(q_data), 128'd0);
      checkOutput("rst_ovf",   128'(ovf),   128'd0);

      // Basic frame with timestamps.
      for (int i = 0; i < 3; i++) begin
         dp_vld  = 1'b1;
         dp_data = 24'h111111 * 24'(i + 1);
         dp_utc  = 32'd5;
         dp_ns   = 32'd100;
         tick();
      end
      dp_vld = 1'b0; dp_utc = '0; dp_ns = '0;
      tick();
      checkOutput("t1_level1", 128'(buf_level), 128'd1);
      checkOutput("t1_waddr",  128'(buf_waddr), 128'd1);
      checkOutput("t1_qvld_pre", 128'(q_vld), 128'd0);
      popOne();
      checkOutput("t1_qvld",  128'(q_vld),  128'd1);
      checkOutput("t1_qdata", 128'(q_data), 128'h333333_222222_111111);
      checkOutput("t1_qutc",  128'(q_utc),  128'd5);
      checkOutput("t1_qns",   128'(q_ns),   128'd100);
      checkOutput("t1_level0", 128'(buf_level), 128'd0);
      tick();
      checkOutput("t1_qvld_drop", 128'(q_vld), 128'd0);
      checkOutput("t1_qdata_hold", 128'(q_data), 128'h333333_222222_111111);
      popOne();
      checkOutput("t1_pop_empty_qvld", 128'(q_vld), 128'd0);
      checkOutput("t1_pop_empty_raddr", 128'(buf_raddr), 128'd1);

      // Overflow: fifth frame into a full store is dropped.
      for (int k = 1; k <= 5; k++) begin
         applyStimulus(3, 8'(k), 1'b0);
         if (k == 3) checkOutput("ovf_full3", 128'(full), 128'd0);
         if (k == 4) checkOutput("ovf_full4", 128'(full), 128'd1);
      end
      checkOutput("ovf_level", 128'(buf_level), 128'd4);
      checkOutput("ovf_flag",  128'(ovf),       128'd1);
      checkOutput("ovf_cnt",   128'(ovf_cnt),   128'd1);
      for (int k = 1; k <= 4; k++) begin
         popOne();
         checkOutput($sformatf("ovf_pop%0d", k), 128'(q_data), 128'(frameWord(8'(k))));
      end
      checkOutput("ovf_empty", 128'(empty), 128'd1);

      // Commit and pop together at full.
      for (int k = 6; k <= 9; k++) applyStimulus(3, 8'(k), 1'b0);
      checkOutput("af_full", 128'(full), 128'd1);
      applyStimulus(3, 8'd10, 1'b1);
      checkOutput("af_level",   128'(buf_level), 128'd4);
      checkOutput("af_ovf_cnt", 128'(ovf_cnt),   128'd1);
      checkOutput("af_qvld",    128'(q_vld),     128'd1);
      checkOutput("af_qdata",   128'(q_data),    128'(frameWord(8'd6)));
      checkOutput("af_qns",     128'(q_ns),      128'd60);
      for (int k = 7; k <= 10; k++) begin
         popOne();
         checkOutput($sformatf("af_pop%0d", k), 128'(q_data), 128'(frameWord(8'(k))));
      end
      checkOutput("af_empty", 128'(empty), 128'd1);

      // Flush back to slot 0, then wrap the pointers with alternating traffic.
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checkOutput("fl_waddr", 128'(buf_waddr), 128'd0);
      wexp = '0;
      for (int k = 20; k < 30; k++) begin
         applyStimulus(3, 8'(k), 1'b0);
         wexp = (wexp == 2'd3) ? 2'd0 : wexp + 2'd1;
         checkOutput($sformatf("wr_waddr%0d", k), 128'(buf_waddr), 128'(wexp));
         popOne();
         checkOutput($sformatf("wr_data%0d", k), 128'(q_data), 128'(frameWord(8'(k))));
      end
      checkOutput("wr_empty", 128'(empty), 128'd1);
      checkOutput("wr_raddr", 128'(buf_raddr), 128'd2);

      // Short and long frames.
      applyStimulus(2, 8'h40, 1'b0);
      checkOutput("sh_cnt",   128'(short_cnt), 128'd1);
      checkOutput("sh_level", 128'(buf_level), 128'd0);
      applyStimulus(5, 8'h41, 1'b0);
      checkOutput("lg_cnt",   128'(long_cnt),  128'd1);
      checkOutput("lg_level", 128'(buf_level), 128'd1);
      popOne();
      checkOutput("lg_data",  128'(q_data), 128'(frameWord(8'h41)));

      // Flush with two records stored and a capture in flight.
      applyStimulus(3, 8'h50, 1'b0);
      applyStimulus(3, 8'h51, 1'b0);
      checkOutput("fl_level2", 128'(buf_level), 128'd2);
      for (int i = 0; i < 2; i++) begin
         dp_vld = 1'b1; dp_data = sampleOf(8'h52, i); tick();
      end
      flush = 1'b1; rd_pop = 1'b1;
      tick();
      flush = 1'b0; rd_pop = 1'b0; dp_vld = 1'b0;
      checkOutput("fl_qvld", 128'(q_vld), 128'd0);
      tick();
      checkOutput("fl_level",  128'(buf_level), 128'd0);
      checkOutput("fl_empty",  128'(empty),     128'd1);
      checkOutput("fl_raddr",  128'(buf_raddr), 128'd0);
      checkOutput("fl_waddr2", 128'(buf_waddr), 128'd0);
      checkOutput("fl_short",  128'(short_cnt), 128'd1);
      checkOutput("fl_long",   128'(long_cnt),  128'd1);
      checkOutput("fl_ovf",    128'(ovf),       128'd1);
      checkOutput("fl_ovfcnt", 128'(ovf_cnt),   128'd1);
      applyStimulus(3, 8'h53, 1'b0);
      checkOutput("fl_after_waddr", 128'(buf_waddr), 128'd1);
      popOne();
      checkOutput("fl_after_data", 128'(q_data), 128'(frameWord(8'h53)));

      // Reset in the middle of a capture.
      applyStimulus(3, 8'h60, 1'b0);
      for (int i = 0; i < 2; i++) begin
         dp_vld = 1'b1; dp_data = sampleOf(8'h61, i); tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0; dp_vld = 1'b0;
      tick();
      checkOutput("mr_level",  128'(buf_level), 128'd0);
      checkOutput("mr_waddr",  128'(buf_waddr), 128'd0);
      checkOutput("mr_short",  128'(short_cnt), 128'd0);
      checkOutput("mr_long",   128'(long_cnt),  128'd0);
      checkOutput("mr_ovf",    128'(ovf),       128'd0);
      checkOutput("mr_ovfcnt", 128'(ovf_cnt),   128'd0);
      checkOutput("mr_qdata",  128'(q_data),    128'd0);
      checkOutput("mr_qutc",   128'(q_utc),     128'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
